// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-stage load/store engine. Takes the effective address, store
//   operand and funct3, runs one data-memory transaction over a req/ready
//   handshake, and returns sign/zero-extended load data. `busy` stalls the
//   pipeline until the access completes, faults or times out.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   start, mem_read, mem_write  request strobe and direction (IDLE only)
//   funct3, addr, wdata         access size/sign, byte address, store data
//   busy, done, err, timeout    status; done pulses once per transaction
//   rdata                       extended load result, held between loads
//   dmem_req/we/addr/be/wdata   memory request channel
//   dmem_ready, dmem_rdata      memory response

// Per byte-lane store steering: byte enable and lane data for one lane.
module lsu_lane #(
  parameter int LANE = 0
) (
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic        be,
  output logic [7:0]  wbyte
);
  localparam logic [1:0] LN = 2'(LANE);

  always_comb begin
    be    = 1'b0;
    wbyte = 8'h00;
    case (funct3[1:0])
      2'b00: begin
        be    = (addr_lo == LN);
        wbyte = wdata[7:0];
      end
      2'b01: begin
        be    = (addr_lo[1] == LN[1]);
        wbyte = LN[0] ? wdata[15:8] : wdata[7:0];
      end
      default: begin
        be    = 1'b1;
        wbyte = wdata[8*LANE +: 8];
      end
    endcase
  end
endmodule

module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int WAIT_LIMIT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  timeout,
  output logic [31:0]           rdata,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [31:0]           dmem_wdata,
  input  logic                  dmem_ready,
  input  logic [31:0]           dmem_rdata
);
  localparam int NUM_LANES = 4;
  localparam logic [7:0] CNT_LAST = 8'(WAIT_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            f3_q;
  logic                  we_q;
  logic [NUM_LANES-1:0]  be_q;
  logic [31:0]           wdata_q;
  logic                  err_q;
  logic                  to_q;
  logic [7:0]            cnt_q;
  logic [31:0]           rdata_q;

  // Store steering computed from the live inputs, captured at accept.
  logic [NUM_LANES-1:0]       lane_be;
  logic [NUM_LANES-1:0][7:0]  lane_wdata;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      lsu_lane #(.LANE(g)) u_lane (
        .funct3  (funct3),
        .addr_lo (addr[1:0]),
        .wdata   (wdata),
        .be      (lane_be[g]),
        .wbyte   (lane_wdata[g])
      );
    end
  endgenerate

  // Request legality. Both read and write at once is illegal; neither is
  // not a request at all and is filtered by `accept`.
  logic accept, size_ok, align_ok, legal;

  assign accept = (state_q == IDLE) && start && (mem_read || mem_write);

  always_comb begin
    size_ok = 1'b0;
    if (mem_read && !mem_write)
      size_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b101);
    else if (mem_write && !mem_read)
      size_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
  end

  always_comb begin
    align_ok = 1'b1;
    case (funct3[1:0])
      2'b01:   align_ok = !addr[0];
      2'b10:   align_ok = (addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
  end

  assign legal = size_ok && align_ok;

  // Load lane select and extension, driven by the latched address/size.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign ld_byte = dmem_rdata[8*addr_q[1:0] +: 8];
  assign ld_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    ld_ext = dmem_rdata;
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  // FSM
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = legal ? REQ : RESP;
      REQ:     if (dmem_ready || cnt_q == CNT_LAST) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      f3_q    <= 3'b000;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= 8'h00;
      rdata_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          addr_q  <= addr;
          f3_q    <= funct3;
          we_q    <= mem_write;
          be_q    <= lane_be;
          wdata_q <= lane_wdata;
          err_q   <= !legal;
          to_q    <= 1'b0;
          cnt_q   <= 8'h00;
        end
        REQ: begin
          if (dmem_ready) begin
            if (!we_q) rdata_q <= ld_ext;
          end else begin
            cnt_q <= cnt_q + 8'h01;
            if (cnt_q == CNT_LAST) to_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: request-channel qualifiers read as zero outside REQ.
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == RESP);
  assign err        = done && err_q;
  assign timeout    = done && to_q;
  assign rdata      = rdata_q;
  assign dmem_req   = (state_q == REQ);
  assign dmem_we    = dmem_req && we_q;
  assign dmem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign dmem_be    = dmem_req ? be_q : 4'b0000;
  assign dmem_wdata = dmem_we ? wdata_q : 32'h0;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (WAIT_LIMIT = 4). Inputs are driven
// and outputs sampled 1 time unit after each rising edge.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        busy, done, err, timeout;
  logic [31:0] rdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  int checks = 0;
  int errors = 0;
  int done_cnt;

  load_store_unit #(.ADDR_WIDTH(32), .WAIT_LIMIT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .timeout    (timeout),
    .rdata      (rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request in the current cycle (cycle 0), then advance to cycle 1.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    start = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    tick();
    start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // Load with ready in cycle 1; returns positioned in the done cycle.
  task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    issue(1'b1, 1'b0, f3, a, 32'h0);
    dmem_ready = 1'b1; dmem_rdata = rd;
    tick();
    dmem_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    dmem_ready = 1'b0; dmem_rdata = 32'h0;
    tick(); tick();

    // Reset state
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_req",   dmem_req, 0);
    check("rst_be",    dmem_be, 0);
    check("rst_addr",  dmem_addr, 0);
    check("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    tick();

    // start with neither direction is ignored
    start = 1'b1; tick(); start = 1'b0;
    check("nop_busy", busy, 0);

    // LW normal
    issue(1'b1, 1'b0, 3'b010, 32'h1004, 32'h0);
    check("lw_req",  dmem_req, 1);
    check("lw_we",   dmem_we, 0);
    check("lw_addr", dmem_addr, 32'h1004);
    check("lw_be",   dmem_be, 4'hF);
    check("lw_busy", busy, 1);
    check("lw_done1", done, 0);
    dmem_ready = 1'b1; dmem_rdata = 32'hDEADBEEF;
    tick();
    dmem_ready = 1'b0;
    check("lw_done",  done, 1);
    check("lw_err",   err, 0);
    check("lw_rdata", rdata, 32'hDEADBEEF);
    check("lw_req2",  dmem_req, 0);
    tick();
    check("lw_idle", busy, 0);

    // Load extension
    load(3'b000, 32'h2003, 32'h80123456);
    check("lb_rdata", rdata, 32'hFFFFFF80);
    tick();
    load(3'b100, 32'h2003, 32'h80123456);
    check("lbu_rdata", rdata, 32'h00000080);
    tick();
    load(3'b001, 32'h2000, 32'h80128765);
    check("lh_rdata", rdata, 32'hFFFF8765);
    tick();
    load(3'b101, 32'h2002, 32'h80123456);
    check("lhu_rdata", rdata, 32'h00008012);
    tick();

    // SH upper half
    issue(1'b0, 1'b1, 3'b001, 32'h3002, 32'h0000ABCD);
    check("sh_we",    dmem_we, 1);
    check("sh_be",    dmem_be, 4'hC);
    check("sh_wdata", dmem_wdata, 32'hABCDABCD);
    check("sh_addr",  dmem_addr, 32'h3000);
    dmem_ready = 1'b1; dmem_rdata = 32'h11111111;
    tick();
    dmem_ready = 1'b0;
    check("sh_done",  done, 1);
    check("sh_rdata", rdata, 32'h00008012);
    tick();

    // SB lane 1
    issue(1'b0, 1'b1, 3'b000, 32'h5001, 32'h123456A5);
    check("sb_be",    dmem_be, 4'h2);
    check("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    check("sb_done", done, 1);
    tick();

    // Illegal requests: done+err in cycle 1, no memory request
    issue(1'b1, 1'b0, 3'b010, 32'h4002, 32'h0);
    check("ilw_done", done, 1); check("ilw_err", err, 1); check("ilw_req", dmem_req, 0);
    tick();
    check("ilw_idle", busy, 0);
    issue(1'b0, 1'b1, 3'b001, 32'h4001, 32'h0);
    check("ish_done", done, 1); check("ish_err", err, 1); check("ish_req", dmem_req, 0);
    tick();
    issue(1'b0, 1'b1, 3'b100, 32'h4000, 32'h0);
    check("isf_done", done, 1); check("isf_err", err, 1); check("isf_req", dmem_req, 0);
    tick();
    issue(1'b1, 1'b1, 3'b010, 32'h4000, 32'h0);
    check("irw_err", err, 1); check("irw_req", dmem_req, 0);
    tick();

    // Timeout with a second start pulse in cycle 2
    issue(1'b1, 1'b0, 3'b010, 32'h6000, 32'h0);
    done_cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("to_req_c%0d", c), dmem_req, (c <= 4) ? 1 : 0);
      if (done) done_cnt++;
      if (c == 5) begin
        check("to_done", done, 1);
        check("to_flag", timeout, 1);
        check("to_err",  err, 0);
        check("to_rdata", rdata, 32'h00008012);
      end
      if (c == 2) begin
        start = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h7000;
      end else begin
        start = 1'b0; mem_read = 1'b0;
      end
      tick();
    end
    check("to_one_done", done_cnt, 1);
    check("to_idle", busy, 0);

    // Reset mid-REQ
    issue(1'b1, 1'b0, 3'b010, 32'h1008, 32'h0);
    tick();
    check("mr_req_c2", dmem_req, 1);
    rst_n = 1'b0;
    tick();
    check("mr_req",   dmem_req, 0);
    check("mr_busy",  busy, 0);
    check("mr_rdata", rdata, 0);
    check("mr_done",  done, 0);
    rst_n = 1'b1;
    tick();
    check("mr_done2", done, 0);
    load(3'b010, 32'h1004, 32'h12345678);
    check("post_done",  done, 1);
    check("post_rdata", rdata, 32'h12345678);
    tick();
    check("post_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit in the memory stage. It takes the ALU's computed effective address (ALUResult) plus the store operand and funct3, and runs one data-memory transaction over a req/ready handshake. It generates byte enables and store-lane replication, and sign/zero-extends load data. It stalls the core via `busy` until the access completes, faults, or times out.

## Interface
- `ADDR_WIDTH`, 32: width of `addr` and `dmem_addr`.
- `WAIT_LIMIT`, 255: maximum cycles in REQ without `dmem_ready` before timeout; range 1..255.

- `clk` input 1: sole clock; all state updates on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `start` input 1: transaction request; sampled only in IDLE.
- `mem_read` input 1: load request; qualifies `start`.
- `mem_write` input 1: store request; qualifies `start`.
- `funct3` input 3: access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `addr` input ADDR_WIDTH: effective byte address (ALUResult).
- `wdata` input 32: store data (rs2).
- `busy` output 1: high whenever state ≠ IDLE; stalls the pipeline.
- `done` output 1: one-cycle pulse when a transaction ends, whether it succeeds or fails.
- `err` output 1: high with `done` for a misaligned or illegal request.
- `timeout` output 1: high with `done` when `WAIT_LIMIT` expires.
- `rdata` output 32: extended load result; holds its value between loads.
- `dmem_req` output 1: memory request, held until accepted.
- `dmem_we` output 1: 1 = write.
- `dmem_addr` output ADDR_WIDTH: word-aligned address `{addr[W-1:2],2'b00}`.
- `dmem_be` output 4: byte enables; bit i enables byte i ([7:0] = byte 0).
- `dmem_wdata` output 32: lane-replicated store data.
- `dmem_ready` input 1: memory accepts/completes the access in this cycle.
- `dmem_rdata` input 32: read data, valid when `dmem_ready`=1 on a read.

## Operation
- States are IDLE, REQ and RESP.
- **IDLE:**
  - `start`=1 with exactly one of `mem_read`/`mem_write`: latch `addr`, `wdata`, `funct3` and direction, then check legality.
  - Legal request: go to REQ.
  - Illegal request: go to RESP with `err` set. No memory access is made.
  - `start` with neither read nor write: ignored.
  - `start` with both read and write: illegal.
- **Illegal requests:**
  - A load with funct3 ∉ {000,001,010,100,101}.
  - A store with funct3 ∉ {000,001,010}.
  - A halfword with `addr[0]`=1.
  - A word with `addr[1:0]`≠00.
- **REQ:**
  - Drive `dmem_req`=1, with `dmem_we`, `dmem_addr`, `dmem_be` and `dmem_wdata` all stable.
  - The wait counter clears on entry and increments each cycle `dmem_ready`=0.
  - `dmem_ready`=1: for a load, register the extended data into `rdata`. Go to RESP.
  - Counter reaches `WAIT_LIMIT` with no ready: go to RESP with `timeout` set. `rdata` is unchanged.
- **RESP:** `done`=1 for one cycle, plus `err`/`timeout` if set. Then go to IDLE.
- **Byte enables:**
  - B: `be = 1<<addr[1:0]`.
  - H: `be` = 0011 when `addr[1]`=0, 1100 when `addr[1]`=1.
  - W: `be` = 1111.
- **Store data:** B replicates `wdata[7:0]` ×4; H replicates `wdata[15:0]` ×2; W passes `wdata` through.
- **Load extension:**
  - The lane is selected by `addr[1:0]` (B) or `addr[1]` (H).
  - 000/001 sign-extend; 100/101 zero-extend.
  - W loads take `dmem_rdata` unchanged.
- `start` is ignored while `busy`=1. A pulse arriving during a transaction is lost, not queued.
- `dmem_be`, `dmem_we` and `dmem_wdata` read as 0 when `dmem_req`=0.

## Timing
- **Reset:** state=IDLE. `busy`, `done`, `err`, `timeout`, `dmem_req`, `dmem_we` = 0; `dmem_be`=0; `dmem_addr`, `dmem_wdata`, `rdata` = 0; wait counter = 0.
- **Reset mid-transaction:** the clock edge with `rst_n`=0 returns to IDLE. `dmem_req` is low from that edge, and no `done` is produced.
- **Legal access:** `start` in cycle 0, `dmem_req` high in cycle 1.
  - `dmem_ready` sampled high in cycle k≥1 ends the request; `dmem_req` is low from k+1.
  - `done` is high in k+1; `busy` is high in cycles 1..k+1.
  - Minimum latency is 2 cycles (start → done).
- **Illegal access:** `done`+`err` in cycle 1; `dmem_req` never asserts.
- **Timeout:** `dmem_req` is high in cycles 1..`WAIT_LIMIT`. `done`+`timeout` in cycle `WAIT_LIMIT`+1.
- **`rdata` update:** takes its new value at the same edge that enters RESP, so it is valid when `done`=1.
- **Back-to-back:** a new `start` is accepted in the cycle after `done`, the first cycle with `busy`=0.

## Test plan
- **LW, normal:** `addr`=0x1004, `dmem_rdata`=0xDEADBEEF, ready in cycle 1 → `dmem_addr`=0x1004, `be`=1111; `done` in cycle 2; `rdata`=0xDEADBEEF.
- **LB/LBU extension:** `addr`=0x2003, `dmem_rdata`=0x80123456 → LB gives `rdata`=0xFFFFFF80; LBU gives 0x00000080; LHU at 0x2002 gives 0x00008012.
- **SH upper half:** `addr`=0x3002, `wdata`=0x0000ABCD → `dmem_we`=1, `be`=1100, `dmem_wdata`=0xABCDABCD, `dmem_addr`=0x3000. A later load shows `rdata` unchanged.
- **Illegal requests:** LW at 0x4002, SH at 0x4001, store with funct3=100 → each gives `done`+`err` in cycle 1; `dmem_req` stays 0.
- **Timeout and ignored start:** `WAIT_LIMIT`=4, `dmem_ready` held 0, `start` pulsed again in cycle 2 → `dmem_req` high in cycles 1–4; `done`+`timeout` in cycle 5; exactly one `done`.
- **Reset mid-REQ:** `rst_n`=0 in cycle 2 of a wait → at the next edge `dmem_req`=0, `busy`=0, `rdata`=0; no `done`. A new LW started afterwards completes normally.
